cache_line_fill_ctrl: RTL and testbench

// - Writer side of the instruction-cache valid/dirty tag latch: owns the 32 per-line

---
 rtl/cache_line_fill_ctrl_pkg.sv | 24 ++
 rtl/cache_line_fill_ctrl_if.sv | 24 ++
 rtl/cache_line_fill_ctrl_valid_reg.sv | 28 ++
 rtl/cache_line_fill_ctrl.sv | 117 +++++++++++
 tb/tb_cache_line_fill_ctrl.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/cache_line_fill_ctrl_pkg.sv
// Shared definitions for the instruction-cache line-fill path: geometry of the
// cache (also used by the tag-bit select mux and the cache RAM) and the
// encoding of the fill FSM states.
package cache_line_fill_ctrl_pkg;

    localparam int NUM_LINES  = 32;
    localparam int LINE_BYTES = 16;
    localparam int LINE_W     = $clog2(NUM_LINES);
    localparam int OFF_W      = $clog2(LINE_BYTES);
    localparam int CADDR_W    = LINE_W + OFF_W;

    typedef logic [LINE_W-1:0] line_idx_t;
    typedef logic [OFF_W-1:0]  offset_t;

    localparam offset_t OFF_LAST = offset_t'(LINE_BYTES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } fill_state_t;

endpackage

// File: rtl/cache_line_fill_ctrl_if.sv
// Memory read bus and cache RAM write port seen by the line-fill controller.
// The controller is the master; memory and cache RAM sit on the slave side.
interface cache_line_fill_ctrl_if;
    import cache_line_fill_ctrl_pkg::*;

    logic               mem_req;
    offset_t            mem_offset;
    logic               mem_ack;
    logic [7:0]         mem_data;
    logic               cache_we;
    logic [CADDR_W-1:0] cache_waddr;
    logic [7:0]         cache_wdata;

    modport master (
        output mem_req, mem_offset, cache_we, cache_waddr, cache_wdata,
        input  mem_ack, mem_data
    );

    modport slave (
        input  mem_req, mem_offset, cache_we, cache_waddr, cache_wdata,
        output mem_ack, mem_data
    );

endinterface

// File: rtl/cache_line_fill_ctrl_valid_reg.sv
// Per-line valid bits read by the tag-bit select mux. Clear-all beats set,
// set beats clear (the controller never asserts set and clr together).
module cache_valid_reg
    import cache_line_fill_ctrl_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 clr_all,
    input  logic                 set,
    input  logic                 clr,
    input  line_idx_t            idx,
    output logic [NUM_LINES-1:0] bits
);

    // Valid-bit register: synchronous reset, then clear-all, set, clear.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            bits <= '0;
        end else if (clr_all) begin
            bits <= '0;
        end else if (set) begin
            bits[idx] <= 1'b1;
        end else if (clr) begin
            bits[idx] <= 1'b0;
        end
    end

endmodule

// File: rtl/cache_line_fill_ctrl.sv
// Instruction-cache line-fill controller: on a miss, reads the 16 bytes of the
// line from memory one at a time, writes each into cache RAM, then marks the
// line valid. Flush clears every valid bit and abandons any fill in progress.
module cache_line_fill_ctrl
    import cache_line_fill_ctrl_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   flush,
    input  logic                   miss_req,
    input  line_idx_t              miss_line,
    cache_line_fill_ctrl_if.master bus,
    output logic [NUM_LINES-1:0]   valid_bits,
    output logic                   fill_busy,
    output logic                   fill_done
);

    fill_state_t state, next_state;
    offset_t     cnt, cnt_next;
    line_idx_t   line_q, line_next;
    logic [7:0]  data_q, data_next;
    logic        mem_req_q, cache_we_q;
    logic        v_clr_all, v_set, v_clr;

    // Next-state, counter, datapath and valid-bit update decisions.
    // NOTE: every signal gets a default before the case so no latch is inferred.
    always_comb begin
        next_state = state;
        cnt_next   = cnt;
        line_next  = line_q;
        data_next  = data_q;
        v_clr_all  = 1'b0;
        v_set      = 1'b0;
        v_clr      = 1'b0;

        if (flush) begin
            next_state = ST_IDLE;
            cnt_next   = '0;
            v_clr_all  = 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (miss_req) begin
                        line_next  = miss_line;
                        cnt_next   = '0;
                        v_clr      = 1'b1;
                        next_state = ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (bus.mem_ack) begin
                        data_next  = bus.mem_data;
                        next_state = ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if (cnt == OFF_LAST) begin
                        // Bit becomes visible together with the fill_done pulse.
                        v_set      = 1'b1;
                        next_state = ST_DONE;
                    end else begin
                        cnt_next   = cnt + offset_t'(1);
                        next_state = ST_REQ;
                    end
                end
                ST_DONE: begin
                    cnt_next   = '0;
                    next_state = ST_IDLE;
                end
                default: begin
                    next_state = ST_IDLE;
                end
            endcase
        end
    end

    // State, datapath and registered strobes decoded from the next state.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            line_q     <= '0;
            data_q     <= '0;
            mem_req_q  <= 1'b0;
            cache_we_q <= 1'b0;
            fill_busy  <= 1'b0;
            fill_done  <= 1'b0;
        end else begin
            state      <= next_state;
            cnt        <= cnt_next;
            line_q     <= line_next;
            data_q     <= data_next;
            mem_req_q  <= (next_state == ST_REQ);
            cache_we_q <= (next_state == ST_WRITE);
            fill_busy  <= (next_state != ST_IDLE);
            fill_done  <= (next_state == ST_DONE);
        end
    end

    cache_valid_reg u_valid (
        .clk     (clk),
        .reset_n (reset_n),
        .clr_all (v_clr_all),
        .set     (v_set),
        .clr     (v_clr),
        .idx     (line_next),
        .bits    (valid_bits)
    );

    assign bus.mem_req     = mem_req_q;
    assign bus.mem_offset  = cnt;
    assign bus.cache_we    = cache_we_q;
    assign bus.cache_waddr = {line_q, cnt};
    assign bus.cache_wdata = data_q;

endmodule

// File: tb/tb_cache_line_fill_ctrl.sv
// Bench for the line-fill controller. The bench plays the memory (random wait
// states, random data) and keeps its own picture of the valid bits, the bytes
// each line should receive and the cycle cost of every fill.
module tb_cache_line_fill_ctrl;
    import cache_line_fill_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        flush = 1'b0;
    logic        miss_req = 1'b0;
    logic [4:0]  miss_line = '0;
    logic [31:0] valid_bits;
    logic        fill_busy;
    logic        fill_done;

    cache_line_fill_ctrl_if bus ();

    cache_line_fill_ctrl dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .flush      (flush),
        .miss_req   (miss_req),
        .miss_line  (miss_line),
        .bus        (bus.master),
        .valid_bits (valid_bits),
        .fill_busy  (fill_busy),
        .fill_done  (fill_done)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] model_valid = '0;
    logic [7:0]  line_data [16];
    int          perm [32];

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_valid"}, valid_bits, model_valid);
        check({tag, "_busy"}, 32'(fill_busy), 32'd0);
        check({tag, "_mem_req"}, 32'(bus.mem_req), 32'd0);
        check({tag, "_cache_we"}, 32'(bus.cache_we), 32'd0);
        check({tag, "_fill_done"}, 32'(fill_done), 32'd0);
    endtask

    // One miss: request the line, act as memory, check every write, the done
    // pulse, the fill cost and the valid bits. flush_after > 0 raises flush
    // right after that many writes; poke_line >= 0 asserts a competing miss.
    task automatic run_fill(input int line, input int wmin, input int wmax,
                            input int flush_after, input int poke_line, input bit spurious_ack);
        int idx = 0;
        int cyc = 0;
        int exp_cyc = 1;
        int waits = 0;
        int wtarget = -1;
        int stray = 0;
        bit done_seen = 1'b0;
        bit flushed = 1'b0;
        logic [31:0] waddr_exp;

        miss_line = 5'(line);
        miss_req  = 1'b1;
        for (int budget = 0; budget < 2000 && !done_seen && !flushed; budget++) begin
            @(negedge clk);
            cyc++;
            bus.mem_ack  = 1'b0;
            bus.mem_data = 8'h00;
            if (cyc == 1) begin
                model_valid[line] = 1'b0;
                check("clr_on_req", valid_bits, model_valid);
                check("busy_on_req", 32'(fill_busy), 32'd1);
            end
            if (poke_line >= 0 && cyc >= 4 && cyc <= 7) begin
                miss_req  = 1'b1;
                miss_line = 5'(poke_line);
            end else begin
                miss_req = 1'b0;
            end

            if (fill_done) begin
                done_seen = 1'b1;
                model_valid[line] = 1'b1;
                check("done_byte_count", 32'(idx), 32'd16);
                check("fill_cycles", 32'(cyc), 32'(exp_cyc));
                check("valid_at_done", valid_bits, model_valid);
            end else if (bus.cache_we) begin
                waddr_exp = 32'(line * 16 + idx);
                check("cache_waddr", 32'(bus.cache_waddr), waddr_exp);
                check("cache_wdata", 32'(bus.cache_wdata), 32'(line_data[idx]));
                check("req_low_in_write", 32'(bus.mem_req), 32'd0);
                idx++;
                if (spurious_ack) begin
                    bus.mem_ack  = 1'($urandom_range(1, 0));
                    bus.mem_data = 8'($urandom);
                end
                if (idx == flush_after) begin
                    flush   = 1'b1;
                    flushed = 1'b1;
                end
            end else if (bus.mem_req) begin
                if (wtarget < 0) begin
                    wtarget = int'($urandom_range(wmax, wmin));
                    waits   = 0;
                    exp_cyc += 2 + wtarget;
                    check("mem_offset", 32'(bus.mem_offset), 32'(idx));
                end
                if (waits == wtarget) begin
                    bus.mem_ack  = 1'b1;
                    bus.mem_data = line_data[idx];
                    wtarget      = -1;
                end else begin
                    waits++;
                end
            end
        end
        miss_req = 1'b0;

        if (flushed) begin
            @(negedge clk);
            flush        = 1'b0;
            bus.mem_ack  = 1'b0;
            model_valid  = '0;
            check_idle_outputs("after_flush");
            for (int i = 0; i < 40; i++) begin
                @(negedge clk);
                if (bus.cache_we || fill_done || fill_busy) stray++;
            end
            check("no_activity_after_flush", 32'(stray), 32'd0);
        end else begin
            check("fill_done_seen", 32'(done_seen), 32'd1);
            @(negedge clk);
            check_idle_outputs("after_done");
        end
    endtask

    task automatic random_line_data();
        for (int i = 0; i < 16; i++) line_data[i] = 8'($urandom);
    endtask

    initial begin
        int tmp;
        int j;
        bus.mem_ack  = 1'b0;
        bus.mem_data = 8'h00;

        // Reset held for two edges, with a miss request that must be ignored.
        reset_n   = 1'b0;
        miss_req  = 1'b1;
        miss_line = 5'd4;
        repeat (2) @(negedge clk);
        check_idle_outputs("reset");
        reset_n  = 1'b1;
        miss_req = 1'b0;
        @(negedge clk);
        check_idle_outputs("post_reset");

        // Line 5, two wait states per byte, data 0xA0 + offset.
        for (int i = 0; i < 16; i++) line_data[i] = 8'(8'hA0 + i);
        run_fill(5, 2, 2, 0, -1, 1'b0);
        check("valid_line5", valid_bits, 32'h0000_0020);

        // Line 31 with ack in the same cycle as the request.
        random_line_data();
        run_fill(31, 0, 0, 0, -1, 1'b0);
        check("valid_line31", valid_bits, 32'h8000_0020);

        // mem_ack while idle must not start anything.
        for (int i = 0; i < 4; i++) begin
            bus.mem_ack  = 1'b1;
            bus.mem_data = 8'($urandom);
            @(negedge clk);
            check_idle_outputs("idle_ack");
        end
        bus.mem_ack = 1'b0;

        // Flush right after the 7th write of line 2.
        random_line_data();
        run_fill(2, 0, 3, 7, -1, 1'b0);

        // Fill every line in random order with random waits and stray acks.
        for (int i = 0; i < 32; i++) perm[i] = i;
        for (int i = 31; i > 0; i--) begin
            j = int'($urandom_range(i, 0));
            tmp = perm[i]; perm[i] = perm[j]; perm[j] = tmp;
        end
        for (int i = 0; i < 32; i++) begin
            random_line_data();
            run_fill(perm[i], 0, 3, 0, -1, 1'b1);
        end
        check("all_valid", valid_bits, 32'hFFFF_FFFF);

        // Refill line 3 while valid; a miss for line 9 mid-fill is ignored.
        random_line_data();
        run_fill(3, 0, 2, 0, 9, 1'b0);

        // Flush and miss_req together: flush wins, request dropped.
        @(negedge clk);
        flush     = 1'b1;
        miss_req  = 1'b1;
        miss_line = 5'($urandom);
        @(negedge clk);
        flush       = 1'b0;
        miss_req    = 1'b0;
        model_valid = '0;
        check_idle_outputs("flush_with_miss");
        @(negedge clk);
        check_idle_outputs("flush_with_miss_hold");

        // Flush in the last write: no valid bit, no done pulse.
        random_line_data();
        run_fill(7, 0, 1, 16, -1, 1'b0);

        // Normal operation after the flushes.
        random_line_data();
        run_fill(12, 1, 4, 0, -1, 1'b1);
        check("valid_line12", valid_bits, 32'h0000_1000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
